// File: rtl/sram_rr_scheduler.sv
// Round-robin arbiter sharing one asynchronous 128Kx16 SRAM among NUM_REQ
// valid/ready requesters, with a fixed-timing SETUP/STROBE/RECOVER access sequencer.
module sram_rr_scheduler #(
    parameter int NUM_REQ     = 3,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*17-1:0] req_addr,
    input  logic [NUM_REQ*16-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [15:0]           rsp_rdata,
    output logic [16:0]           sram_a,
    inout  wire  [15:0]           sram_dq,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  sram_ub_n,
    output logic                  sram_lb_n
);
    localparam int         PTR_W     = $clog2(NUM_REQ);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_RECOVER} state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_port;
    logic               r_we;
    logic [16:0]        r_addr;
    logic [15:0]        r_wdata;
    logic [15:0]        r_rdata;
    logic [3:0]         r_cnt;
    logic               r_we_n;
    logic               r_oe_n;
    logic               r_dq_oe;
    logic [NUM_REQ-1:0] r_rsp_valid;

    logic [PTR_W-1:0]   w_grant_idx;
    logic [PTR_W-1:0]   w_scan_idx;
    logic               w_grant_any;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_grant_idx = r_rr_ptr;
        w_grant_any = 1'b0;
        w_scan_idx  = '0;
        // Scan backwards so the last hit is the first valid port after the pointer.
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_scan_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (req_valid[w_scan_idx]) begin
                w_grant_idx = w_scan_idx;
                w_grant_any = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == S_IDLE && w_grant_any)
            req_ready[w_grant_idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= PTR_W'(NUM_REQ - 1);
            r_port      <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_cnt       <= '0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_rsp_valid <= '0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_port   <= w_grant_idx;
                        r_rr_ptr <= w_grant_idx;
                        r_we     <= req_we[w_grant_idx];
                        r_addr   <= req_addr[17*int'(w_grant_idx) +: 17];
                        r_wdata  <= req_wdata[16*int'(w_grant_idx) +: 16];
                        r_dq_oe  <= req_we[w_grant_idx];
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_cnt   <= WAIT_LOAD;
                    r_we_n  <= ~r_we;
                    r_oe_n  <= r_we;
                    r_state <= S_STROBE;
                end
                S_STROBE: begin
                    if (r_cnt == 4'd0) begin
                        r_we_n              <= 1'b1;
                        r_oe_n              <= 1'b1;
                        r_rsp_valid[r_port] <= 1'b1;
                        if (!r_we)
                            r_rdata <= sram_dq;
                        r_state <= S_RECOVER;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RECOVER: begin
                    r_dq_oe <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign sram_a    = r_addr;
    assign sram_we_n = r_we_n;
    assign sram_oe_n = r_oe_n;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;
    assign sram_dq   = r_dq_oe ? r_wdata : 16'hzzzz;

endmodule

// File: tb/tb_sram_rr_scheduler.sv
// Scoreboard bench: two schedulers (WAIT_CYCLES=2 and =1), each on its own
// behavioural SRAM; expected responses are queued at accept and checked on rsp_valid.
module tb_sram_rr_scheduler;
    localparam int NREQ   = 3;
    localparam int WAIT_A = 2;
    localparam int WAIT_B = 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req_valid, req_we, req_ready, rsp_valid;
    logic [NREQ*17-1:0] req_addr;
    logic [NREQ*16-1:0] req_wdata;
    logic [15:0]        rsp_rdata;
    logic [16:0]        sram_a;
    wire  [15:0]        sram_dq;
    logic               sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    logic [NREQ-1:0]    b_req_valid, b_req_we, b_req_ready, b_rsp_valid;
    logic [NREQ*17-1:0] b_req_addr;
    logic [NREQ*16-1:0] b_req_wdata;
    logic [15:0]        b_rsp_rdata;
    logic [16:0]        b_sram_a;
    wire  [15:0]        b_sram_dq;
    logic               b_sram_oe_n, b_sram_we_n, b_sram_ub_n, b_sram_lb_n;

    sram_rr_scheduler #(.NUM_REQ(NREQ), .WAIT_CYCLES(WAIT_A)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_a(sram_a), .sram_dq(sram_dq), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    sram_rr_scheduler #(.NUM_REQ(NREQ), .WAIT_CYCLES(WAIT_B)) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .sram_a(b_sram_a), .sram_dq(b_sram_dq), .sram_oe_n(b_sram_oe_n),
        .sram_we_n(b_sram_we_n), .sram_ub_n(b_sram_ub_n), .sram_lb_n(b_sram_lb_n)
    );

    // Behavioural asynchronous SRAMs
    logic [15:0] mem_a [0:131071];
    logic [15:0] mem_b [0:131071];
    assign sram_dq   = (!sram_oe_n && sram_we_n) ? mem_a[sram_a] : 16'hzzzz;
    assign b_sram_dq = (!b_sram_oe_n && b_sram_we_n) ? mem_b[b_sram_a] : 16'hzzzz;
    always @(negedge clk) if (!sram_we_n) mem_a[sram_a] = sram_dq;

    typedef struct {
        int          port;
        logic        we;
        logic [15:0] data;
        int          cyc;
    } txn_t;

    txn_t        sb_q[$];
    txn_t        b_q[$];
    int          grant_port[$];
    int          grant_cyc[$];
    logic [15:0] ref_mem [int];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          we_low = 0, oe_low = 0, b_oe_low = 0, b_last_acc = -1;
    int          wait_n;
    logic [15:0] cur_wdata = '0, last_rd = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    task automatic set_req(input int p, input logic we, input logic [16:0] a, input logic [15:0] d);
        req_we[p]            = we;
        req_addr[17*p +: 17] = a;
        req_wdata[16*p +: 16] = d;
    endtask

    // Drops each port's valid once it has been accepted; called just after a posedge.
    task automatic drain(input int max_cycles);
        logic [NREQ-1:0] hs;
        int n = 0;
        while (req_valid != '0 && n < max_cycles) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            n++;
            @(posedge clk);
            #1 req_valid = req_valid & ~hs;
        end
        check("drain_timeout", 32'(req_valid), 0);
        req_valid = '0;
    endtask

    task automatic issue(input int p, input logic we, input logic [16:0] a, input logic [15:0] d);
        set_req(p, we, a, d);
        req_valid[p] = 1'b1;
        drain(50);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the WAIT_CYCLES=2 instance
    logic [NREQ-1:0] hs_a;
    int              gp, a_a;
    txn_t            t_a;
    always @(negedge clk) begin
        if (reset_n) begin
            if (!sram_we_n) begin
                we_low++;
                check("wr_dq", 32'(sram_dq), 32'(cur_wdata));
                check("oe_during_we", 32'(sram_oe_n), 1);
            end
            if (!sram_oe_n) oe_low++;
            if (rsp_valid != '0) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 0);
                end else begin
                    t_a = sb_q.pop_front();
                    check("rsp_port", 32'(rsp_valid), 32'(1) << t_a.port);
                    check("rsp_latency", cyc - t_a.cyc, 2 + WAIT_A);
                    if (t_a.we) begin
                        check("we_low_cycles", we_low, WAIT_A);
                        check("rdata_hold", 32'(rsp_rdata), 32'(last_rd));
                    end else begin
                        check("oe_low_cycles", oe_low, WAIT_A);
                        check("rd_data", 32'(rsp_rdata), 32'(t_a.data));
                        last_rd = t_a.data;
                    end
                end
            end
            hs_a = req_valid & req_ready;
            if (hs_a != '0) begin
                check("ready_onehot", $countones(req_ready), 1);
                gp = 0;
                for (int i = 0; i < NREQ; i++) if (hs_a[i]) gp = i;
                a_a      = int'(req_addr[17*gp +: 17]);
                t_a.port = gp;
                t_a.we   = req_we[gp];
                t_a.cyc  = cyc;
                if (t_a.we) begin
                    t_a.data     = req_wdata[16*gp +: 16];
                    ref_mem[a_a] = t_a.data;
                    cur_wdata    = t_a.data;
                end else begin
                    t_a.data = ref_rd(a_a);
                end
                sb_q.push_back(t_a);
                grant_port.push_back(gp);
                grant_cyc.push_back(cyc);
                we_low = 0;
                oe_low = 0;
            end
        end
    end

    // Scoreboard for the WAIT_CYCLES=1 instance (port 0 reads only)
    txn_t t_b;
    always @(negedge clk) begin
        if (reset_n) begin
            if (!b_sram_oe_n) b_oe_low++;
            if (b_rsp_valid != '0) begin
                if (b_q.size() == 0) begin
                    check("b_rsp_unexpected", 32'(b_rsp_valid), 0);
                end else begin
                    t_b = b_q.pop_front();
                    check("b_rsp_port", 32'(b_rsp_valid), 1);
                    check("b_rsp_latency", cyc - t_b.cyc, 2 + WAIT_B);
                    check("b_oe_low_cycles", b_oe_low, WAIT_B);
                    check("b_rd_data", 32'(b_rsp_rdata), 32'(t_b.data));
                end
            end
            if (b_req_valid[0] && b_req_ready[0]) begin
                if (b_last_acc >= 0) check("b_accept_gap", cyc - b_last_acc, 3 + WAIT_B);
                b_last_acc = cyc;
                t_b.port   = 0;
                t_b.we     = 1'b0;
                t_b.cyc    = cyc;
                t_b.data   = mem_b[b_req_addr[16:0]];
                b_q.push_back(t_b);
                b_oe_low = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 131072; i++) begin
            mem_a[i] = 16'h0000;
            mem_b[i] = 16'h0000;
        end
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        b_req_valid = '0; b_req_we = '0; b_req_addr = '0; b_req_wdata = '0;
        mem_a[17'h00020] = 16'h5A5A;
        ref_mem[32'h20]  = 16'h5A5A;
        for (int k = 0; k < 4; k++) mem_b[17'h00100 + k] = 16'hC3A0 + 16'(k * 16'h0111);

        // Reset values and quiet idle behaviour
        repeat (3) @(posedge clk);
        #1;
        check("rst_we_n", 32'(sram_we_n), 1);
        check("rst_oe_n", 32'(sram_oe_n), 1);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rdata", 32'(rsp_rdata), 0);
        check("rst_addr", 32'(sram_a), 0);
        check("rst_dq_hiz", 32'(sram_dq === 16'hzzzz), 1);
        check("ub_lb_tied", {30'd0, sram_ub_n, sram_lb_n}, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("idle_strobes", {30'd0, sram_we_n, sram_oe_n}, 3);
            check("idle_ready", 32'(req_ready), 0);
            check("idle_rsp", 32'(rsp_valid), 0);
        end
        check("idle_dq_hiz", 32'(sram_dq === 16'hzzzz), 1);
        @(posedge clk);
        #1;

        // All ports continuously valid: rotation 0,1,2,0,1,2 at one grant per 3+WAIT cycles
        set_req(0, 1'b1, 17'h00010, 16'hA5A5);
        set_req(1, 1'b0, 17'h00010, 16'h0000);
        set_req(2, 1'b0, 17'h00020, 16'h0000);
        grant_port.delete();
        grant_cyc.delete();
        req_valid = '1;
        wait_n = 0;
        while (grant_port.size() < 6 && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        @(posedge clk);
        #1 req_valid = '0;
        check("rr_grant_count", grant_port.size(), 6);
        for (int i = 0; i < grant_port.size() && i < 6; i++) check("rr_order", grant_port[i], i % 3);
        for (int i = 1; i < grant_cyc.size() && i < 6; i++)
            check("rr_spacing", grant_cyc[i] - grant_cyc[i-1], 3 + WAIT_A);
        wait_idle();

        // Pointer at port 0, then ports 0 and 2 together: port 2 wins first
        issue(0, 1'b0, 17'h00020, 16'h0000);
        wait_idle();
        grant_port.delete();
        grant_cyc.delete();
        set_req(0, 1'b0, 17'h00020, 16'h0000);
        set_req(2, 1'b1, 17'h00030, 16'h3C3C);
        req_valid = 3'b101;
        drain(100);
        wait_idle();
        check("simul_grant_count", grant_port.size(), 2);
        if (grant_port.size() >= 2) begin
            check("simul_first", grant_port[0], 2);
            check("simul_second", grant_port[1], 0);
        end

        // Port 1 write then read-back
        issue(1, 1'b1, 17'h1ABCD, 16'hBEEF);
        wait_idle();
        issue(1, 1'b0, 17'h1ABCD, 16'h0000);
        wait_idle();

        // Reset asserted during the strobe of a write
        issue(0, 1'b1, 17'h00055, 16'h1234);
        wait_n = 0;
        while (sram_we_n && wait_n < 10) begin
            @(negedge clk);
            wait_n++;
        end
        check("abort_in_strobe", 32'(sram_we_n), 0);
        #2 reset_n = 1'b0;
        #1;
        check("abort_we_n", 32'(sram_we_n), 1);
        check("abort_oe_n", 32'(sram_oe_n), 1);
        check("abort_dq_hiz", 32'(sram_dq === 16'hzzzz), 1);
        check("abort_rsp_valid", 32'(rsp_valid), 0);
        check("abort_rdata", 32'(rsp_rdata), 0);
        sb_q.delete();
        last_rd = 16'h0000;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(rsp_valid), 0);
        end
        @(posedge clk);
        #1;
        issue(2, 1'b0, 17'h1ABCD, 16'h0000);
        wait_idle();

        // WAIT_CYCLES=1 instance: back-to-back reads from port 0
        b_last_acc     = -1;
        b_req_valid[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b_req_addr[16:0] = 17'h00100 + 17'(k);
            wait_n = 0;
            do begin
                @(negedge clk);
                wait_n++;
            end while (!b_req_ready[0] && wait_n < 20);
            check("b_grant", 32'(b_req_ready[0]), 1);
            @(posedge clk);
            #1;
        end
        b_req_valid = '0;
        wait_n = 0;
        while (b_q.size() != 0 && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check("b_idle_timeout", b_q.size(), 0);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
